// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the single-clock FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width: clog2 of the depth, never narrower than one bit.
  function automatic int fifo_addr_size(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit fifo_params_ok(input int depth, input int fwft,
                                        input int af_thresh, input int ae_thresh);
    return (depth >= 2) && (fwft == 0 || fwft == 1) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_regfile #(
  parameter int DATA_SIZE  = 32,
  parameter int DATA_DEPTH = 16,
  parameter int ADDR_SIZE  = 4
) (
  input  logic                 clk,
  input  logic                 i_w_en,
  input  logic [ADDR_SIZE-1:0] i_w_addr,
  input  logic [DATA_SIZE-1:0] i_w_data,
  input  logic [ADDR_SIZE-1:0] i_r_addr,
  output logic [DATA_SIZE-1:0] o_r_data
);

  logic [DATA_SIZE-1:0] r_mem [DATA_DEPTH];

  // NOTE: the array has no reset; occupancy lives in the pointers and count,
  // so stale contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_w_en) r_mem[i_w_addr] <= i_w_data;
  end

  assign o_r_data = r_mem[i_r_addr];

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// synchronous flush, sticky error flags and standard or FWFT read mode.
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int DATA_DEPTH = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DATA_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int ADDR_SIZE = fifo_addr_size(DATA_DEPTH),
  localparam int CNT_SIZE  = $clog2(DATA_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 flush,
  input  logic                 w_en,
  input  logic [DATA_SIZE-1:0] w_data,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  input  logic                 r_en,
  output logic [DATA_SIZE-1:0] r_data,
  output logic                 r_valid,
  output logic                 empty,
  output logic                 almost_empty,
  output logic                 underflow,
  input  logic                 err_clr,
  output logic [CNT_SIZE-1:0]  count
);

  if (!fifo_params_ok(DATA_DEPTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("synchronous_fifo: illegal DATA_DEPTH/FWFT/threshold parameters");
  end

  localparam fifo_mode_e           MODE      = fifo_mode_e'(FWFT != 0);
  localparam logic [CNT_SIZE-1:0]  DEPTH_CNT = CNT_SIZE'(DATA_DEPTH);
  localparam logic [CNT_SIZE-1:0]  AF_CNT    = CNT_SIZE'(AF_THRESH);
  localparam logic [CNT_SIZE-1:0]  AE_CNT    = CNT_SIZE'(AE_THRESH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(DATA_DEPTH - 1);

  logic [ADDR_SIZE-1:0] r_w_ptr, r_r_ptr;
  logic [CNT_SIZE-1:0]  r_count;
  logic                 r_overflow, r_underflow;
  logic [DATA_SIZE-1:0] w_mem_rdata;
  logic                 w_full, w_empty, w_w_acc, w_r_acc, w_mem_we;
  logic                 w_ovf_evt, w_unf_evt;

  // Explicit wrap so non-power-of-two depths never walk past the last entry.
  function automatic logic [ADDR_SIZE-1:0] ptr_next(input logic [ADDR_SIZE-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  assign w_full    = (r_count == DEPTH_CNT);
  assign w_empty   = (r_count == '0);
  assign w_w_acc   = w_en & ~w_full;
  assign w_r_acc   = r_en & ~w_empty;
  assign w_mem_we  = nrst & ~flush & w_w_acc;
  assign w_ovf_evt = ~flush & w_en & w_full;
  assign w_unf_evt = ~flush & r_en & w_empty;

  fifo_regfile #(
    .DATA_SIZE (DATA_SIZE),
    .DATA_DEPTH(DATA_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_regfile (
    .clk     (clk),
    .i_w_en  (w_mem_we),
    .i_w_addr(r_w_ptr),
    .i_w_data(w_data),
    .i_r_addr(r_r_ptr),
    .o_r_data(w_mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_w_ptr <= '0;
      r_r_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_w_acc) r_w_ptr <= ptr_next(r_w_ptr);
      if (w_r_acc) r_r_ptr <= ptr_next(r_r_ptr);
      if (w_w_acc && !w_r_acc)      r_count <= r_count + CNT_SIZE'(1);
      else if (!w_w_acc && w_r_acc) r_count <= r_count - CNT_SIZE'(1);
    end
  end

  // A fresh error event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt)    r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_unf_evt)    r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign r_data  = w_mem_rdata;
    assign r_valid = ~w_empty;
  end else begin : g_std
    logic [DATA_SIZE-1:0] r_rdata;
    logic                 r_rvalid;

    always_ff @(posedge clk) begin
      if (!nrst) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end else if (flush) begin
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_r_acc;
        if (w_r_acc) r_rdata <= w_mem_rdata;
      end
    end

    assign r_data  = r_rdata;
    assign r_valid = r_rvalid;
  end

  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_synchronous_fifo.sv
// Drives a standard-mode depth-8 FIFO and an FWFT depth-6 FIFO with the same
// stimulus and compares both against queue-based reference models.
module tb_synchronous_fifo;

  localparam int DW = 16;
  typedef logic [DW-1:0] q_t [$];

  logic clk = 1'b0;
  logic nrst, flush, w_en, r_en, err_clr;
  logic [DW-1:0] w_data;

  logic          a_full, a_af, a_ovf, a_rvalid, a_empty, a_ae, a_unf;
  logic [DW-1:0] a_rdata;
  logic [3:0]    a_count;
  logic          b_full, b_af, b_ovf, b_rvalid, b_empty, b_ae, b_unf;
  logic [DW-1:0] b_rdata;
  logic [2:0]    b_count;

  synchronous_fifo #(.DATA_SIZE(DW), .DATA_DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) dut_std (
    .clk(clk), .nrst(nrst), .flush(flush), .w_en(w_en), .w_data(w_data),
    .full(a_full), .almost_full(a_af), .overflow(a_ovf), .r_en(r_en),
    .r_data(a_rdata), .r_valid(a_rvalid), .empty(a_empty), .almost_empty(a_ae),
    .underflow(a_unf), .err_clr(err_clr), .count(a_count)
  );

  synchronous_fifo #(.DATA_SIZE(DW), .DATA_DEPTH(6), .FWFT(1), .AF_THRESH(5), .AE_THRESH(1)) dut_fwft (
    .clk(clk), .nrst(nrst), .flush(flush), .w_en(w_en), .w_data(w_data),
    .full(b_full), .almost_full(b_af), .overflow(b_ovf), .r_en(r_en),
    .r_data(b_rdata), .r_valid(b_rvalid), .empty(b_empty), .almost_empty(b_ae),
    .underflow(b_unf), .err_clr(err_clr), .count(b_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  q_t qa, qb;
  bit ovf_a, unf_a, ovf_b, unf_b, rv_a, rv_b;
  logic [DW-1:0] rd_a, rd_b;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference behaviour: a queue of stored words plus sticky flags.
  task automatic model(input int depth, inout q_t q, inout bit ovf, inout bit unf,
                       inout bit rv, inout logic [DW-1:0] rd);
    bit is_full, is_empty;
    if (!nrst) begin
      q.delete(); ovf = 0; unf = 0; rv = 0; rd = '0;
    end else begin
      is_full  = (q.size() == depth);
      is_empty = (q.size() == 0);
      if (!flush && w_en && is_full)       ovf = 1;
      else if (err_clr)                    ovf = 0;
      if (!flush && r_en && is_empty)      unf = 1;
      else if (err_clr)                    unf = 0;
      rv = 0;
      if (flush) q.delete();
      else begin
        if (r_en && !is_empty) begin rd = q.pop_front(); rv = 1; end
        if (w_en && !is_full) q.push_back(w_data);
      end
    end
  endtask

  task automatic compare_all();
    check("a_count", a_count, qa.size());
    check("a_full", a_full, qa.size() == 8);
    check("a_empty", a_empty, qa.size() == 0);
    check("a_almost_full", a_af, qa.size() >= 6);
    check("a_almost_empty", a_ae, qa.size() <= 2);
    check("a_overflow", a_ovf, ovf_a);
    check("a_underflow", a_unf, unf_a);
    check("a_r_valid", a_rvalid, rv_a);
    check("a_r_data", a_rdata, rd_a);
    check("b_count", b_count, qb.size());
    check("b_full", b_full, qb.size() == 6);
    check("b_empty", b_empty, qb.size() == 0);
    check("b_almost_full", b_af, qb.size() >= 5);
    check("b_almost_empty", b_ae, qb.size() <= 1);
    check("b_overflow", b_ovf, ovf_b);
    check("b_underflow", b_unf, unf_b);
    check("b_r_valid", b_rvalid, qb.size() != 0);
    if (qb.size() != 0) check("b_r_data", b_rdata, qb[0]);
  endtask

  task automatic cycle(input bit we, input logic [DW-1:0] wd, input bit re,
                       input bit fl, input bit ec);
    w_en = we; w_data = wd; r_en = re; flush = fl; err_clr = ec;
    @(posedge clk);
    model(8, qa, ovf_a, unf_a, rv_a, rd_a);
    model(6, qb, ovf_b, unf_b, rv_b, rd_b);
    #1 compare_all();
  endtask

  initial begin
    int nw, nr, guard;
    nrst = 1'b0; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; w_data = '0;

    // Reset with both requests active.
    cycle(1, 16'h00ff, 1, 0, 0);
    cycle(1, 16'h00ff, 1, 0, 0);
    check("rst_empty", a_empty, 1);
    check("rst_r_data", a_rdata, 0);
    nrst = 1'b1;

    // Fill past full, then drain past empty.
    for (int i = 1; i <= 9; i++) begin
      cycle(1, DW'(i), 0, 0, 0);
      if (i == 5) check("af_before_thresh", a_af, 0);
      if (i == 6) check("af_at_thresh", a_af, 1);
      if (i == 8) check("full_after_8", a_full, 1);
      if (i == 9) check("overflow_on_9th", a_ovf, 1);
    end
    for (int i = 1; i <= 9; i++) begin
      cycle(0, '0, 1, 0, 0);
      if (i <= 8) begin
        check("drain_r_valid", a_rvalid, 1);
        check("drain_r_data", a_rdata, i);
      end else check("underflow_on_9th", a_unf, 1);
    end
    cycle(0, '0, 0, 0, 1);
    check("err_clr_ovf", a_ovf, 0);

    // Simultaneous read/write at a steady occupancy of four.
    for (int i = 0; i < 4; i++) cycle(1, DW'(16'h40 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, DW'(16'h50 + i), 1, 0, 0);
      check("rw_count_steady", a_count, 4);
    end
    cycle(0, '0, 0, 1, 0);

    // Stream 20 words with random gaps through both FIFOs; never overfill or overdrain.
    nw = 0; nr = 0; guard = 0;
    while (nr < 20 && guard < 400) begin
      bit we, re;
      we = (nw < 20) && (qa.size() < 6) && ($urandom_range(0, 1) == 1);
      re = (qa.size() > 0) && ($urandom_range(0, 2) != 0);
      cycle(we, DW'(16'h100 + nw), re, 0, 0);
      if (we) nw++;
      if (a_rvalid) begin
        check("stream_order", a_rdata, 16'h100 + nr);
        nr++;
      end
      guard++;
    end
    check("stream_all_read", nr, 20);
    check("stream_no_overflow", a_ovf | b_ovf, 0);
    check("stream_no_underflow", a_unf | b_unf, 0);

    // FWFT: first word appears without a read request.
    cycle(1, 16'h00a5, 0, 0, 0);
    check("fwft_not_empty", b_empty, 0);
    check("fwft_r_valid", b_rvalid, 1);
    check("fwft_r_data", b_rdata, 16'h00a5);
    cycle(0, '0, 1, 0, 0);
    check("fwft_empty_after_pop", b_empty, 1);

    // Flush at count 5 with a pending write and overflow set.
    for (int i = 0; i < 9; i++) cycle(1, DW'(16'h200 + i), 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0);
    check("pre_flush_count", a_count, 5);
    cycle(1, 16'h2ff, 0, 1, 0);
    check("flush_count", a_count, 0);
    check("flush_keeps_ovf", a_ovf, 1);
    cycle(0, '0, 0, 0, 1);
    check("err_clr_after_flush", a_ovf, 0);

    // Random soak including flush, error clear and one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      nrst = (i != 150);
      cycle($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
    end
    nrst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
